// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B front end (sync, glitch filter, Gray decode); define QUAD_X4_EN for x4 stepping, otherwise x1
module quad_decoder #(
  parameter int P_FILT = 3,
  parameter int P_BIT  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic             step,
  output logic             up_dw,
  output logic [P_BIT-1:0] position,
  output logic             err,
  output logic             err_sticky
);
`ifdef QUAD_X4_EN
  localparam logic X4 = 1'b1;
`else
  localparam logic X4 = 1'b0;
`endif
  localparam logic [8:0]       PRIME_LEN = 9'(P_FILT + 2);
  localparam logic [7:0]       FILT_LAST = 8'(P_FILT - 1);
  localparam logic [P_BIT-1:0] ONE       = 1;
  logic [1:0]       a_sync_q, b_sync_q;
  logic [7:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic             a_f_q, a_f_d, b_f_q, b_f_d;
  logic [8:0]       prime_cnt_q, prime_cnt_d;
  logic [1:0]       prev_q, prev_d, cur;
  logic             primed, is_up, is_dn, is_bad, cnt_en;
  logic             step_q, step_d, up_dw_q, up_dw_d, err_q, err_d, err_sticky_q, err_sticky_d;
  logic [P_BIT-1:0] pos_q, pos_d;
  // filter, priming and Gray decode next-state
  always_comb begin
    primed       = prime_cnt_q == PRIME_LEN;
    prime_cnt_d  = primed ? prime_cnt_q : prime_cnt_q + 9'd1;
    a_cnt_d      = (!primed || a_sync_q[1] == a_f_q || a_cnt_q == FILT_LAST) ? 8'd0 : a_cnt_q + 8'd1;
    b_cnt_d      = (!primed || b_sync_q[1] == b_f_q || b_cnt_q == FILT_LAST) ? 8'd0 : b_cnt_q + 8'd1;
    a_f_d        = (!primed || a_cnt_q == FILT_LAST) ? a_sync_q[1] : a_f_q;
    b_f_d        = (!primed || b_cnt_q == FILT_LAST) ? b_sync_q[1] : b_f_q;
    cur          = {a_f_q, b_f_q};
    is_up        = cur == {~prev_q[0], prev_q[1]};
    is_dn        = cur == {prev_q[0], ~prev_q[1]};
    is_bad       = cur == ~prev_q;
    cnt_en       = (is_up || is_dn) && (X4 || cur == 2'b00);
    prev_d       = primed ? cur : {a_sync_q[1], b_sync_q[1]};
    step_d       = primed && cnt_en;
    up_dw_d      = (primed && (is_up || is_dn)) ? is_up : up_dw_q;
    err_d        = primed && is_bad;
    err_sticky_d = err_d || (err_sticky_q && !clr);
    pos_d        = clr ? '0 : step_d ? (is_up ? pos_q + ONE : pos_q - ONE) : pos_q;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_sync_q     <= '0;
      b_sync_q     <= '0;
      a_cnt_q      <= '0;
      b_cnt_q      <= '0;
      a_f_q        <= 1'b0;
      b_f_q        <= 1'b0;
      prime_cnt_q  <= '0;
      prev_q       <= '0;
      step_q       <= 1'b0;
      up_dw_q      <= 1'b1;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      pos_q        <= '0;
    end else begin
      a_sync_q     <= {a_sync_q[0], a_in};
      b_sync_q     <= {b_sync_q[0], b_in};
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      a_f_q        <= a_f_d;
      b_f_q        <= b_f_d;
      prime_cnt_q  <= prime_cnt_d;
      prev_q       <= prev_d;
      step_q       <= step_d;
      up_dw_q      <= up_dw_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      pos_q        <= pos_d;
    end
  end
  assign step       = step_q;
  assign up_dw      = up_dw_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign position   = pos_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed plus random quadrature stimulus against a Gray-index reference model
module tb_quad_decoder;
  localparam int P_FILT = 3;
  localparam int LAT = P_FILT + 3;
`ifdef QUAD_X4_EN
  localparam int SPC = 4;
  localparam logic X4 = 1'b1;
`else
  localparam int SPC = 1;
  localparam logic X4 = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, a_in = 1'b1, b_in = 1'b1, clr = 1'b0;
  logic step, up_dw, err, err_sticky;
  logic [15:0] position;
  int n_chk = 0, n_fail = 0, step_cnt = 0, err_cnt = 0;
  logic [1:0] m_st;
  logic [15:0] m_pos;
  logic m_up, m_sticky;
  int m_steps = 0, m_errs = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_decoder #(.P_FILT(P_FILT), .P_BIT(16)) dut (
    .clk(clk), .resetn(resetn), .a_in(a_in), .b_in(b_in), .clr(clr),
    .step(step), .up_dw(up_dw), .position(position), .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gidx(input logic [1:0] s);
    return s == 2'b00 ? 0 : s == 2'b10 ? 1 : s == 2'b11 ? 2 : 3;
  endfunction

  task automatic model(input logic [1:0] s);
    int d;
    d = (gidx(s) - gidx(m_st) + 4) % 4;
    if (d == 2) begin
      m_errs++;
      m_sticky = 1'b1;
    end else if (d != 0) begin
      m_up = d == 1;
      if (X4 || s == 2'b00) begin
        m_steps++;
        m_pos = m_up ? m_pos + 16'd1 : m_pos - 16'd1;
      end
    end
    m_st = s;
  endtask

  task automatic m_reset();
    m_st = {a_in, b_in};
    m_pos = '0;
    m_up = 1'b1;
    m_sticky = 1'b0;
  endtask

  task automatic move(input logic [1:0] s, input int hold);
    {a_in, b_in} = s;
    model(s);
    repeat (hold) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_pos = '0;
    m_sticky = 1'b0;
  endtask

  task automatic check_all(input string t);
    chk({t, ".steps"}, step_cnt, m_steps);
    chk({t, ".errs"}, err_cnt, m_errs);
    chk({t, ".pos"}, position, m_pos);
    chk({t, ".updw"}, up_dw, m_up);
    chk({t, ".sticky"}, err_sticky, m_sticky);
  endtask

  initial begin
    int k, s0, e0, r;
    logic [1:0] nx;
    logic [15:0] exp_rev;
    repeat (3) @(negedge clk);
    chk("rst.step", step, 1'b0);
    chk("rst.updw", up_dw, 1'b1);
    chk("rst.pos", position, 16'd0);
    chk("rst.err", err, 1'b0);
    chk("rst.sticky", err_sticky, 1'b0);
    resetn = 1'b1;
    m_reset();
    repeat (10) @(negedge clk);
    chk("idle.step", step, 1'b0);
    check_all("idle");
    move(2'b01, 10);
    check_all("to01");
    {a_in, b_in} = 2'b00;
    model(2'b00);
    k = 1;
    while (k <= 30) begin
      @(negedge clk);
      if (step === 1'b1) break;
      k++;
    end
    chk("latency", k, LAT);
    repeat (4) @(negedge clk);
    check_all("to00");
    clr_pulse();
    s0 = step_cnt;
    foreach (seq[i]) move(seq[(i + 1) % 4], 8);
    chk("up1.steps", step_cnt - s0, SPC);
    chk("up1.pos", position, SPC);
    chk("up1.updw", up_dw, 1'b1);
    check_all("up1");
    clr_pulse();
    s0 = step_cnt;
    for (int c = 0; c < 2; c++)
      for (int i = 3; i >= 0; i--) move(seq[i], 8);
    exp_rev = 16'(-2 * SPC);
    chk("rev.steps", step_cnt - s0, 2 * SPC);
    chk("rev.pos", position, exp_rev);
    chk("rev.updw", up_dw, 1'b0);
    check_all("rev");
    s0 = step_cnt;
    a_in = 1'b1;
    repeat (2) @(negedge clk);
    a_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch.steps", step_cnt - s0, 0);
    check_all("glitch");
    s0 = step_cnt;
    move(2'b10, 3);
    repeat (7) @(negedge clk);
    chk("held.steps", step_cnt - s0, X4 ? 1 : 0);
    check_all("held");
    move(2'b00, 10);
    check_all("back00");
    s0 = step_cnt;
    e0 = err_cnt;
    move(2'b11, 10);
    chk("bad.errs", err_cnt - e0, 1);
    chk("bad.steps", step_cnt - s0, 0);
    chk("bad.sticky", err_sticky, 1'b1);
    check_all("bad");
    clr_pulse();
    chk("clr.sticky", err_sticky, 1'b0);
    chk("clr.pos", position, 16'd0);
    move(2'b01, 10);
    {a_in, b_in} = 2'b00;
    model(2'b00);
    repeat (LAT - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrstep.step", step, 1'b1);
    chk("clrstep.pos", position, 16'd0);
    m_pos = '0;
    m_sticky = 1'b0;
    repeat (4) @(negedge clk);
    check_all("clrstep");
    clr_pulse();
    s0 = step_cnt;
    for (int c = 0; c < 3; c++)
      for (int i = 1; i <= 4; i++) move(seq[i % 4], 8);
    chk("up3.steps", step_cnt - s0, 3 * SPC);
    chk("up3.pos", position, 3 * SPC);
    check_all("up3");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) move(seq[(gidx(m_st) + 1) % 4], $urandom_range(8, 14));
      else if (r <= 6) move(seq[(gidx(m_st) + 3) % 4], $urandom_range(8, 14));
      else if (r == 7) move(~m_st, $urandom_range(8, 14));
      else if (r == 8) begin
        nx = m_st ^ (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01);
        {a_in, b_in} = nx;
        repeat (2) @(negedge clk);
        {a_in, b_in} = m_st;
        repeat (8) @(negedge clk);
      end else clr_pulse();
      check_all("rand");
    end
    move(seq[(gidx(m_st) + 1) % 4], 10);
    {a_in, b_in} = seq[(gidx(m_st) + 1) % 4];
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mrst.step", step, 1'b0);
    chk("mrst.err", err, 1'b0);
    chk("mrst.pos", position, 16'd0);
    chk("mrst.updw", up_dw, 1'b1);
    chk("mrst.sticky", err_sticky, 1'b0);
    resetn = 1'b1;
    m_reset();
    repeat (12) @(negedge clk);
    check_all("post_rst");
    move(seq[(gidx(m_st) + 3) % 4], 10);
    check_all("post_rst_move");
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
